// File: rtl/xif_coproc_dispatcher.sv
// rtl/xif_coproc_dispatcher.sv - CORE-V-XIF issue/commit/result dispatcher for NUM_CP coprocessors
// Optional protocol checker enabled by defining XIF_DISPATCH_ERR_CHECK_EN.
module xif_coproc_dispatcher #(
    parameter int NUM_CP     = 2,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         core_issue_valid_i,
    output logic                         core_issue_ready_o,
    input  logic [ID_WIDTH-1:0]          core_issue_id_i,
    output logic                         core_issue_accept_o,
    output logic                         core_issue_writeback_o,
    output logic [NUM_CP-1:0]            cp_issue_valid_o,
    input  logic [NUM_CP-1:0]            cp_issue_ready_i,
    input  logic [NUM_CP-1:0]            cp_issue_accept_i,
    input  logic [NUM_CP-1:0]            cp_issue_writeback_i,
    input  logic                         core_commit_valid_i,
    input  logic [ID_WIDTH-1:0]          core_commit_id_i,
    input  logic                         core_commit_kill_i,
    output logic [NUM_CP-1:0]            cp_commit_valid_o,
    input  logic [NUM_CP-1:0]            cp_result_valid_i,
    output logic [NUM_CP-1:0]            cp_result_ready_o,
    input  logic [NUM_CP*ID_WIDTH-1:0]   cp_result_id_i,
    input  logic [NUM_CP*5-1:0]          cp_result_rd_i,
    input  logic [NUM_CP-1:0]            cp_result_we_i,
    input  logic [NUM_CP*DATA_WIDTH-1:0] cp_result_data_i,
    output logic                         core_result_valid_o,
    input  logic                         core_result_ready_i,
    output logic [ID_WIDTH-1:0]          core_result_id_o,
    output logic [4:0]                   core_result_rd_o,
    output logic                         core_result_we_o,
    output logic [DATA_WIDTH-1:0]        core_result_data_o,
    output logic                         busy_o,
    output logic                         err_o
);

    localparam int DEPTH = 2 ** ID_WIDTH;

    logic [DEPTH-1:0] tbl_valid;
    logic [DEPTH-1:0] tbl_wb;
    logic [DEPTH-1:0] valid_nxt;
    logic [DEPTH-1:0] wb_nxt;

    logic             id_busy;
    logic             issue_go;
    logic             any_accept;
    logic             issue_set;
    logic [1:0]       issue_owner;
    logic             owner_wb;
    logic             commit_clr;

    logic [1:0]       rr;
    logic [3:0]       req4;
    logic [2:0]       cand;
    logic [1:0]       gnt;
    logic             found;
    logic             slice_free;
    logic             res_hs;

    logic [ID_WIDTH-1:0]   sel_id;
    logic [4:0]            sel_rd;
    logic                  sel_we;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  out_valid;
    logic [ID_WIDTH-1:0]   out_id;
    logic [4:0]            out_rd;
    logic                  out_we;
    logic [DATA_WIDTH-1:0] out_data;

    // Issue: an ID already in flight blocks the whole broadcast.
    assign id_busy    = tbl_valid[core_issue_id_i];
    assign issue_go   = core_issue_valid_i & ~id_busy & (&cp_issue_ready_i);
    assign any_accept = |cp_issue_accept_i;
    assign issue_set  = issue_go & any_accept;

    always_comb begin
        issue_owner = 2'd0;
        owner_wb    = 1'b0;
        for (int k = NUM_CP - 1; k >= 0; k--) begin
            if (cp_issue_accept_i[k]) begin
                issue_owner = 2'(k);
                owner_wb    = cp_issue_writeback_i[k];
            end
        end
    end

    assign cp_issue_valid_o       = {NUM_CP{issue_go}};
    assign core_issue_ready_o     = issue_go;
    assign core_issue_accept_o    = issue_set;
    assign core_issue_writeback_o = issue_set & owner_wb;

    assign cp_commit_valid_o = {NUM_CP{core_commit_valid_i}};
    assign commit_clr        = core_commit_valid_i & (core_commit_kill_i | ~tbl_wb[core_commit_id_i]);

    // Round-robin search over a zero-padded request vector so the index is always 2 bits.
    assign req4 = 4'(cp_result_valid_i);

    always_comb begin
        gnt   = 2'd0;
        found = 1'b0;
        cand  = 3'd0;
        for (int i = 0; i < NUM_CP; i++) begin
            cand = {1'b0, rr} + 3'(i);
            if (cand >= 3'(NUM_CP)) begin
                cand = cand - 3'(NUM_CP);
            end
            if (!found && req4[cand[1:0]]) begin
                found = 1'b1;
                gnt   = cand[1:0];
            end
        end
    end

    assign slice_free = ~out_valid | core_result_ready_i;
    assign res_hs     = found & slice_free;

    always_comb begin
        cp_result_ready_o = '0;
        sel_id            = '0;
        sel_rd            = '0;
        sel_we            = 1'b0;
        sel_data          = '0;
        for (int k = 0; k < NUM_CP; k++) begin
            if (gnt == 2'(k)) begin
                cp_result_ready_o[k] = res_hs;
                sel_id               = cp_result_id_i[k*ID_WIDTH +: ID_WIDTH];
                sel_rd               = cp_result_rd_i[k*5 +: 5];
                sel_we               = cp_result_we_i[k];
                sel_data             = cp_result_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Clears first, set last; distinct IDs make the order irrelevant in legal traffic.
    always_comb begin
        valid_nxt = tbl_valid;
        wb_nxt    = tbl_wb;
        if (commit_clr) begin
            valid_nxt[core_commit_id_i] = 1'b0;
        end
        if (res_hs) begin
            valid_nxt[sel_id] = 1'b0;
        end
        if (issue_set) begin
            valid_nxt[core_issue_id_i] = 1'b1;
            wb_nxt[core_issue_id_i]    = owner_wb;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tbl_valid <= '0;
            tbl_wb    <= '0;
            rr        <= 2'd0;
            out_valid <= 1'b0;
            out_id    <= '0;
            out_rd    <= '0;
            out_we    <= 1'b0;
            out_data  <= '0;
        end else begin
            tbl_valid <= valid_nxt;
            tbl_wb    <= wb_nxt;
            if (res_hs) begin
                out_valid <= 1'b1;
                out_id    <= sel_id;
                out_rd    <= sel_rd;
                out_we    <= sel_we;
                out_data  <= sel_data;
                rr        <= (gnt == 2'(NUM_CP - 1)) ? 2'd0 : gnt + 2'd1;
            end else if (core_result_ready_i) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign core_result_valid_o = out_valid;
    assign core_result_id_o    = out_id;
    assign core_result_rd_o    = out_rd;
    assign core_result_we_o    = out_we;
    assign core_result_data_o  = out_data;
    assign busy_o              = |tbl_valid;

`ifdef XIF_DISPATCH_ERR_CHECK_EN
    // Owner index is only consulted by the checker.
    logic [1:0] tbl_owner [DEPTH];
    logic       err_q;
    logic       multi_accept;
    logic       res_bad;
    logic       commit_bad;

    assign multi_accept = issue_go & ($countones(cp_issue_accept_i) > 1);
    assign res_bad      = res_hs & (~tbl_valid[sel_id] | (tbl_owner[sel_id] != gnt));
    assign commit_bad   = core_commit_valid_i & ~tbl_valid[core_commit_id_i];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_owner[i] <= 2'd0;
            end
            err_q <= 1'b0;
        end else begin
            if (issue_set) begin
                tbl_owner[core_issue_id_i] <= issue_owner;
            end
            if (multi_accept | res_bad | commit_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_xif_coproc_dispatcher.sv
// tb/tb_xif_coproc_dispatcher.sv - directed bench with a behavioural owner-table/arbiter model
module tb_xif_coproc_dispatcher;
    localparam int N  = 2;
    localparam int IW = 4;
    localparam int DW = 32;
`ifdef XIF_DISPATCH_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            iv;
    logic            irdy;
    logic [IW-1:0]   iid;
    logic            iacc;
    logic            iwb;
    logic [N-1:0]    cp_iv;
    logic [N-1:0]    cp_irdy;
    logic [N-1:0]    cp_acc;
    logic [N-1:0]    cp_wb;
    logic            cv;
    logic [IW-1:0]   cid;
    logic            ckill;
    logic [N-1:0]    cp_cv;
    logic [N-1:0]    rv;
    logic [N-1:0]    rrdy;
    logic [N*IW-1:0] rid;
    logic [N*5-1:0]  rrd;
    logic [N-1:0]    rwe;
    logic [N*DW-1:0] rdata;
    logic            ov;
    logic            ordy;
    logic [IW-1:0]   oid;
    logic [4:0]      ord;
    logic            owe;
    logic [DW-1:0]   odata;
    logic            busy;
    logic            err;

    xif_coproc_dispatcher #(.NUM_CP(N), .ID_WIDTH(IW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk), .rst_i(rst),
        .core_issue_valid_i(iv), .core_issue_ready_o(irdy), .core_issue_id_i(iid),
        .core_issue_accept_o(iacc), .core_issue_writeback_o(iwb),
        .cp_issue_valid_o(cp_iv), .cp_issue_ready_i(cp_irdy),
        .cp_issue_accept_i(cp_acc), .cp_issue_writeback_i(cp_wb),
        .core_commit_valid_i(cv), .core_commit_id_i(cid), .core_commit_kill_i(ckill),
        .cp_commit_valid_o(cp_cv),
        .cp_result_valid_i(rv), .cp_result_ready_o(rrdy), .cp_result_id_i(rid),
        .cp_result_rd_i(rrd), .cp_result_we_i(rwe), .cp_result_data_i(rdata),
        .core_result_valid_o(ov), .core_result_ready_i(ordy),
        .core_result_id_o(oid), .core_result_rd_o(ord), .core_result_we_o(owe),
        .core_result_data_o(odata), .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: owner table as per-ID arrays, result slice as a single held record.
    bit            m_init = 1'b0;
    bit            m_valid [16];
    bit            m_wb    [16];
    int            m_owner [16];
    int            m_rr;
    bit            m_ov;
    logic [IW-1:0] m_id;
    logic [4:0]    m_rd;
    logic          m_we;
    logic [DW-1:0] m_data;
    bit            m_err;

    bit            e_go, e_free, e_busy;
    int            e_own, e_g, e_c, e_rid;
    logic [N-1:0]  e_rdy;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_wb[i]    = 1'b0;
            m_owner[i] = 0;
        end
        m_rr = 0; m_ov = 1'b0; m_id = '0; m_rd = '0; m_we = 1'b0; m_data = '0; m_err = 1'b0;
    endtask

    always @(negedge clk) begin
        e_go  = iv && !m_valid[iid] && (cp_irdy == {N{1'b1}});
        e_own = -1;
        for (int k = 0; k < N; k++) if (e_own < 0 && cp_acc[k]) e_own = k;
        e_free = !m_ov || ordy;
        e_g    = -1;
        for (int i = 0; i < N; i++) begin
            e_c = (m_rr + i) % N;
            if (e_g < 0 && rv[e_c]) e_g = e_c;
        end
        e_rdy = '0;
        if (e_free && e_g >= 0) e_rdy[e_g] = 1'b1;
        e_busy = 1'b0;
        for (int i = 0; i < 16; i++) if (m_valid[i]) e_busy = 1'b1;

        if (m_init) begin
            chk("cp_issue_valid", cp_iv, e_go ? {N{1'b1}} : '0);
            chk("issue_ready", irdy, e_go);
            chk("issue_accept", iacc, e_go && e_own >= 0);
            chk("issue_wb", iwb, (e_go && e_own >= 0) ? cp_wb[e_own] : 1'b0);
            chk("commit_valid", cp_cv, cv ? {N{1'b1}} : '0);
            chk("result_ready", rrdy, e_rdy);
            chk("out_valid", ov, m_ov);
            chk("out_id", oid, m_id);
            chk("out_rd", ord, m_rd);
            chk("out_we", owe, m_we);
            chk("out_data", odata, m_data);
            chk("busy", busy, e_busy);
            chk("err", err, m_err);
        end

        if (rst) begin
            model_reset();
            m_init = 1'b1;
        end else if (m_init) begin
            e_rid = (e_g >= 0) ? int'(rid[e_g*IW +: IW]) : 0;
            if (ERR_EN) begin
                if (e_go && $countones(cp_acc) > 1) m_err = 1'b1;
                if (cv && !m_valid[cid]) m_err = 1'b1;
                if (e_free && e_g >= 0 && (!m_valid[e_rid] || m_owner[e_rid] != e_g)) m_err = 1'b1;
            end
            if (cv && (ckill || !m_wb[cid])) m_valid[cid] = 1'b0;
            if (e_free && e_g >= 0) begin
                m_valid[e_rid] = 1'b0;
                m_ov   = 1'b1;
                m_id   = rid[e_g*IW +: IW];
                m_rd   = rrd[e_g*5 +: 5];
                m_we   = rwe[e_g];
                m_data = rdata[e_g*DW +: DW];
                m_rr   = (e_g + 1) % N;
            end else if (ordy) begin
                m_ov = 1'b0;
            end
            if (e_go && e_own >= 0) begin
                m_valid[iid] = 1'b1;
                m_wb[iid]    = cp_wb[e_own];
                m_owner[iid] = e_own;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic issue(input bit v, input logic [IW-1:0] id, input logic [N-1:0] acc, input logic [N-1:0] wb);
        iv = v; iid = id; cp_acc = acc; cp_wb = wb;
    endtask

    initial begin
        rst = 1'b1; iv = 1'b0; iid = '0; cp_irdy = '1; cp_acc = '0; cp_wb = '0;
        cv = 1'b0; cid = '0; ckill = 1'b0;
        rv = '0; rid = '0; rrd = '0; rwe = '0; rdata = '0; ordy = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        settle();
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_valid", ov, 1'b0);
        chk("rst_out_data", odata, 32'h0);
        chk("rst_err", err, 1'b0);

        // Issue ID 3 to CP1 with writeback, then retry the same ID.
        tick(); issue(1, 4'd3, 2'b10, 2'b10);
        settle();
        chk("iss3_accept", iacc, 1'b1);
        chk("iss3_wb", iwb, 1'b1);
        chk("iss3_busy_before", busy, 1'b0);
        tick();
        settle();
        chk("iss3_busy_after", busy, 1'b1);
        chk("iss3_reissue_ready", irdy, 1'b0);
        tick(); issue(0, 4'd0, 2'b00, 2'b00);

        // CP1 returns the result for ID 3.
        rv = 2'b10; rid = {4'd3, 4'd0}; rrd = {5'd7, 5'd0}; rwe = 2'b10;
        rdata = {32'hCAFE0001, 32'h0};
        settle();
        chk("res3_grant", rrdy, 2'b10);
        tick(); rv = 2'b00;
        settle();
        chk("res3_valid", ov, 1'b1);
        chk("res3_id", oid, 4'd3);
        chk("res3_rd", ord, 5'd7);
        chk("res3_data", odata, 32'hCAFE0001);
        chk("res3_busy", busy, 1'b0);
        tick();
        settle();
        chk("res3_drained", ov, 1'b0);

        // Both CPs keep results pending: grants alternate, then a 3-cycle stall.
        tick();
        rv = 2'b11; rid = {4'd2, 4'd1}; rrd = {5'd2, 5'd1}; rwe = 2'b11;
        rdata = {32'hB1B1B1B1, 32'hA0A0A0A0};
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("rr_grant", rrdy, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick();
        end
        ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("stall_ready", rrdy, 2'b00);
            chk("stall_data", odata, 32'hB1B1B1B1);
            tick();
        end
        rv = 2'b00; ordy = 1'b1;
        tick();
        settle();
        chk("stall_drained", ov, 1'b0);

        // wb=0 entry cleared by a normal commit; killed entry cleared too.
        tick(); issue(1, 4'd5, 2'b01, 2'b00);
        tick(); issue(0, 4'd0, 2'b00, 2'b00);
        cv = 1'b1; cid = 4'd5; ckill = 1'b0;
        settle();
        chk("commit5_bcast", cp_cv, 2'b11);
        chk("commit5_busy", busy, 1'b1);
        tick(); cv = 1'b0;
        issue(1, 4'd5, 2'b00, 2'b00);
        settle();
        chk("reissue5_ready", irdy, 1'b1);
        chk("reissue5_noaccept", iacc, 1'b0);
        tick(); issue(1, 4'd6, 2'b10, 2'b10);
        tick(); issue(0, 4'd0, 2'b00, 2'b00);
        cv = 1'b1; cid = 4'd6; ckill = 1'b1;
        tick(); cv = 1'b0; ckill = 1'b0;
        settle();
        chk("kill6_busy", busy, 1'b0);

        // wb=1 entry survives commit, cleared by its result while ID 8 issues.
        tick(); issue(1, 4'd4, 2'b01, 2'b01);
        tick(); issue(0, 4'd0, 2'b00, 2'b00);
        cv = 1'b1; cid = 4'd4;
        tick(); cv = 1'b0;
        settle();
        chk("commit4_kept", busy, 1'b1);
        tick();
        rv = 2'b01; rid = {4'd0, 4'd4}; rdata = {32'h0, 32'h00000044};
        issue(1, 4'd8, 2'b10, 2'b10);
        tick(); rv = 2'b00; issue(0, 4'd0, 2'b00, 2'b00);
        settle();
        chk("res4_id", oid, 4'd4);
        chk("res4_busy_id8", busy, 1'b1);

        // Reset while a result is held and ID 8 is in flight.
        tick(); ordy = 1'b0; rv = 2'b01; rid = {4'd0, 4'd2};
        tick(); rv = 2'b00; rst = 1'b1;
        tick(); rst = 1'b0; ordy = 1'b1;
        settle();
        chk("mrst_valid", ov, 1'b0);
        chk("mrst_data", odata, 32'h0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_err", err, 1'b0);

        // Dual accept: owner is CP0; then an unowned result is still forwarded.
        tick(); issue(1, 4'd11, 2'b11, 2'b01);
        settle();
        chk("dual_accept", iacc, 1'b1);
        chk("dual_wb_cp0", iwb, 1'b1);
        tick(); issue(0, 4'd0, 2'b00, 2'b00);
        settle();
        chk("dual_err", err, ERR_EN);
        tick();
        rv = 2'b10; rid = {4'd9, 4'd0}; rdata = {32'h99999999, 32'h0};
        tick(); rv = 2'b00;
        settle();
        chk("unowned_fwd_id", oid, 4'd9);
        chk("unowned_err", err, ERR_EN);
        tick();
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
